// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only character LCD writer: timed power-on init, then one
// "label + digits" frame at line 1, column 0 for every digit vector accepted.
module lcd_hd44780_ctrl #(
   parameter int               NUM_DIGITS     = 5,
   parameter int               LABEL_LEN      = 9,
   parameter logic [8*15-1:0]  LABEL          = "NHOM 14: ",
   parameter bit               HEX_EN         = 1'b0,
   parameter bit               BLANK_LZ       = 1'b0,
   parameter int               POWERON_CYC    = 2000000,
   parameter int               E_PULSE_CYC    = 25,
   parameter int               CMD_WAIT_CYC   = 2500,
   parameter int               CLEAR_WAIT_CYC = 100000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic                    upd_valid_i,
   output logic                    upd_ready_o,
   output logic                    init_done_o,
   output logic                    busy_o,
   output logic                    lcd_e,
   output logic                    lcd_rs,
   output logic                    lcd_rw,
   output logic [7:0]              lcd_data
);

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_IDLE,
      ST_ADDR,
      ST_LABEL,
      ST_DIGITS
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } phase_t;

   state_t                  state_reg;
   phase_t                  phase_reg;
   logic [31:0]             cnt_reg;
   logic [3:0]              idx_reg;
   logic [4*NUM_DIGITS-1:0] digits_reg;
   logic                    lcd_e_reg;
   logic                    lcd_rs_reg;
   logic [7:0]              lcd_data_reg;
   logic                    upd_ready_reg;
   logic                    init_done_reg;
   logic                    busy_reg;

   logic [7:0]              label_arr [16];
   logic [7:0]              dig_char  [16];
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    lz_run;
   logic [3:0]              idx_next;
   logic [3:0]              dsel_top;
   logic [3:0]              dsel_next;
   logic [31:0]             hold_last;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      logic [7:0] c;
      case (i)
         2'd0:    c = 8'h38;
         2'd1:    c = 8'h0C;
         2'd2:    c = 8'h06;
         default: c = 8'h01;
      endcase
      return c;
   endfunction

   // Label characters as a flat table; leftmost character sits in the
   // most significant byte of the LABEL_LEN-byte packed constant.
   genvar gi;
   for (gi = 0; gi < 16; gi++) begin : g_label
      if (gi < LABEL_LEN) begin : g_used
         assign label_arr[gi] = LABEL[8*(LABEL_LEN-1-gi) +: 8];
      end else begin : g_unused
         assign label_arr[gi] = 8'h20;
      end
   end

   // A digit is blanked while every digit from it up to the top is zero;
   // digit 0 is excluded so an all-zero vector still shows one '0'.
   always_comb begin
      lz_run     = 1'b1;
      blank_mask = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         lz_run        = lz_run && (digits_reg[4*i +: 4] == 4'd0);
         blank_mask[i] = BLANK_LZ && lz_run;
      end
   end

   for (gi = 0; gi < 16; gi++) begin : g_digit
      if (gi < NUM_DIGITS) begin : g_used
         logic [3:0] dval;
         assign dval = digits_reg[4*gi +: 4];
         assign dig_char[gi] = blank_mask[gi]  ? 8'h20 :
                               (dval < 4'd10)  ? (8'h30 + {4'h0, dval}) :
                               HEX_EN          ? (8'h37 + {4'h0, dval}) :
                                                 8'h3F;
      end else begin : g_unused
         assign dig_char[gi] = 8'h20;
      end
   end

   assign idx_next  = idx_reg + 4'd1;
   assign dsel_top  = 4'(NUM_DIGITS - 1);
   assign dsel_next = dsel_top - idx_next;
   assign hold_last = (!lcd_rs_reg && lcd_data_reg == 8'h01) ? 32'(CLEAR_WAIT_CYC - 1)
                                                              : 32'(CMD_WAIT_CYC - 1);

   // The byte-sending states share one SETUP/PULSE/HOLD sequencer; when HOLD
   // expires, the current state decides the next byte and loads it straight
   // into SETUP so rs/data only ever change while lcd_e is low.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ST_PWR_WAIT;
         phase_reg     <= PH_SETUP;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         digits_reg    <= '0;
         lcd_e_reg     <= 1'b0;
         lcd_rs_reg    <= 1'b0;
         lcd_data_reg  <= 8'h00;
         upd_ready_reg <= 1'b0;
         init_done_reg <= 1'b0;
         busy_reg      <= 1'b1;
      end else begin
         case (state_reg)
            ST_PWR_WAIT: begin
               if (cnt_reg >= 32'(POWERON_CYC - 1)) begin
                  cnt_reg      <= '0;
                  idx_reg      <= '0;
                  state_reg    <= ST_INIT;
                  phase_reg    <= PH_SETUP;
                  lcd_rs_reg   <= 1'b0;
                  lcd_data_reg <= init_cmd(2'd0);
               end else begin
                  cnt_reg <= cnt_reg + 32'd1;
               end
            end

            ST_IDLE: begin
               if (upd_valid_i && upd_ready_reg) begin
                  digits_reg    <= digits_i;
                  upd_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= ST_ADDR;
                  phase_reg     <= PH_SETUP;
                  cnt_reg       <= '0;
                  idx_reg       <= '0;
                  lcd_rs_reg    <= 1'b0;
                  lcd_data_reg  <= 8'h80;
               end
            end

            default: begin
               case (phase_reg)
                  PH_SETUP: begin
                     lcd_e_reg <= 1'b1;
                     phase_reg <= PH_PULSE;
                     cnt_reg   <= '0;
                  end

                  PH_PULSE: begin
                     if (cnt_reg >= 32'(E_PULSE_CYC - 1)) begin
                        lcd_e_reg <= 1'b0;
                        phase_reg <= PH_HOLD;
                        cnt_reg   <= '0;
                     end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                     end
                  end

                  default: begin
                     if (cnt_reg >= hold_last) begin
                        cnt_reg   <= '0;
                        phase_reg <= PH_SETUP;
                        case (state_reg)
                           ST_INIT: begin
                              if (idx_reg == 4'd3) begin
                                 state_reg     <= ST_IDLE;
                                 init_done_reg <= 1'b1;
                                 upd_ready_reg <= 1'b1;
                                 busy_reg      <= 1'b0;
                              end else begin
                                 idx_reg      <= idx_next;
                                 lcd_data_reg <= init_cmd(idx_next[1:0]);
                              end
                           end

                           ST_ADDR: begin
                              idx_reg    <= '0;
                              lcd_rs_reg <= 1'b1;
                              if (LABEL_LEN > 0) begin
                                 state_reg    <= ST_LABEL;
                                 lcd_data_reg <= label_arr[0];
                              end else begin
                                 state_reg    <= ST_DIGITS;
                                 lcd_data_reg <= dig_char[dsel_top];
                              end
                           end

                           ST_LABEL: begin
                              if (idx_reg == 4'(LABEL_LEN - 1)) begin
                                 state_reg    <= ST_DIGITS;
                                 idx_reg      <= '0;
                                 lcd_data_reg <= dig_char[dsel_top];
                              end else begin
                                 idx_reg      <= idx_next;
                                 lcd_data_reg <= label_arr[idx_next];
                              end
                           end

                           ST_DIGITS: begin
                              if (idx_reg == 4'(NUM_DIGITS - 1)) begin
                                 state_reg     <= ST_IDLE;
                                 upd_ready_reg <= 1'b1;
                                 busy_reg      <= 1'b0;
                              end else begin
                                 idx_reg      <= idx_next;
                                 lcd_data_reg <= dig_char[dsel_next];
                              end
                           end

                           default: state_reg <= ST_PWR_WAIT;
                        endcase
                     end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                     end
                  end
               endcase
            end
         endcase
      end
   end

   assign upd_ready_o = upd_ready_reg;
   assign init_done_o = init_done_reg;
   assign busy_o      = busy_reg;
   assign lcd_e       = lcd_e_reg;
   assign lcd_rs      = lcd_rs_reg;
   assign lcd_rw      = 1'b0;
   assign lcd_data    = lcd_data_reg;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: three instances (plain, hex, blanking) share
// stimulus; a scoreboard checks every enable pulse against queued bytes.
module tb_lcd_hd44780_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] digits = '0;
   logic        valid = 1'b0;

   logic [2:0]  ready_w, done_w, busy_w, e_w, rs_w, rw_w;
   logic [7:0]  data_w [3];

   int n_cmp = 0;
   int n_mis = 0;

   logic [8:0]  q0 [$];
   logic [8:0]  q1 [$];
   logic [8:0]  q2 [$];

   logic [71:0] lbl;

   typedef struct {
      logic [19:0] digits;
      logic [39:0] s_plain;
      logic [39:0] s_hex;
      logic [39:0] s_blz;
      bit          scramble;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      lcd_hd44780_ctrl #(
         .NUM_DIGITS     (5),
         .LABEL_LEN      (9),
         .HEX_EN         (gi == 1),
         .BLANK_LZ       (gi == 2),
         .POWERON_CYC    (20),
         .E_PULSE_CYC    (2),
         .CMD_WAIT_CYC   (4),
         .CLEAR_WAIT_CYC (10)
      ) u_dut (
         .clk_i       (clk),
         .rst_i       (rst),
         .digits_i    (digits),
         .upd_valid_i (valid),
         .upd_ready_o (ready_w[gi]),
         .init_done_o (done_w[gi]),
         .busy_o      (busy_w[gi]),
         .lcd_e       (e_w[gi]),
         .lcd_rs      (rs_w[gi]),
         .lcd_rw      (rw_w[gi]),
         .lcd_data    (data_w[gi])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_all(input logic [8:0] v0, input logic [8:0] v1, input logic [8:0] v2);
      q0.push_back(v0);
      q1.push_back(v1);
      q2.push_back(v2);
   endtask

   task automatic flush_all();
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   task automatic push_frame(input logic [39:0] sp, input logic [39:0] sh, input logic [39:0] sb);
      logic [8:0] c;
      push_all(9'h080, 9'h080, 9'h080);
      for (int j = 0; j < 9; j++) begin
         c = {1'b1, lbl[8*(8-j) +: 8]};
         push_all(c, c, c);
      end
      for (int j = 0; j < 5; j++)
         push_all({1'b1, sp[8*(4-j) +: 8]}, {1'b1, sh[8*(4-j) +: 8]}, {1'b1, sb[8*(4-j) +: 8]});
   endtask

   task automatic check_queues_empty(input string tag);
      check({tag, "_q0_left"}, 32'(q0.size()), 32'd0);
      check({tag, "_q1_left"}, 32'(q1.size()), 32'd0);
      check({tag, "_q2_left"}, 32'(q2.size()), 32'd0);
   endtask

   // Scoreboard: every rising lcd_e pops the byte expected next; rs/data
   // must not move while the pulse is high.
   logic [2:0] e_prev = '0;
   logic [8:0] rise_val [3];
   always @(negedge clk) begin
      logic [8:0] got;
      logic [8:0] exp;
      bit         have;
      for (int i = 0; i < 3; i++) begin
         got = {rs_w[i], data_w[i]};
         if (e_w[i] && !e_prev[i]) begin
            have = 1'b0;
            exp  = '0;
            case (i)
               0: if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
               1: if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
            endcase
            check($sformatf("pulse_expected[%0d]", i), 32'(have), 32'd1);
            if (have)
               check($sformatf("pulse_rs_data[%0d]", i), 32'(got), 32'(exp));
            check($sformatf("pulse_rw[%0d]", i), 32'(rw_w[i]), 32'd0);
            rise_val[i] <= got;
         end else if (!e_w[i] && e_prev[i] && !rst) begin
            check($sformatf("byte_stable[%0d]", i), 32'(got), 32'(rise_val[i]));
         end
      end
      e_prev <= e_w;
   end

   // Called at a negedge with rst high; releases reset and follows the
   // power-on wait and the four init commands cycle by cycle.
   task automatic run_init();
      bit exp_e;
      check("rst_lcd_e",     32'(e_w[0]),    32'd0);
      check("rst_lcd_rs",    32'(rs_w[0]),   32'd0);
      check("rst_lcd_rw",    32'(rw_w[0]),   32'd0);
      check("rst_lcd_data",  32'(data_w[0]), 32'h00);
      check("rst_ready",     32'(ready_w),   32'd0);
      check("rst_init_done", 32'(done_w),    32'd0);
      check("rst_busy",      32'(busy_w),    32'h7);
      flush_all();
      for (int j = 0; j < 4; j++) begin
         logic [7:0] cmd;
         case (j)
            0: cmd = 8'h38;
            1: cmd = 8'h0C;
            2: cmd = 8'h06;
            default: cmd = 8'h01;
         endcase
         push_all({1'b0, cmd}, {1'b0, cmd}, {1'b0, cmd});
      end
      rst = 1'b0;
      for (int k = 1; k <= 54; k++) begin
         @(negedge clk);
         exp_e = (k >= 21 && k <= 43 && ((k - 21) % 7) < 2);
         check($sformatf("init_lcd_e@%0d", k), 32'(e_w[0]), 32'(exp_e));
         check($sformatf("init_ready@%0d", k), 32'(ready_w[0]), 32'(k >= 54));
         check($sformatf("init_done@%0d", k), 32'(done_w[0]), 32'(k >= 54));
      end
      check("init_busy_idle", 32'(busy_w[0]), 32'd0);
      check_queues_empty("init");
   endtask

   // Wait (bounded) for upd_ready_o, returning the number of low samples.
   task automatic wait_ready(input bit scramble, output int lowcnt);
      lowcnt = 0;
      while (ready_w[0] == 1'b0 && lowcnt < 400) begin
         lowcnt++;
         if (scramble) digits = 20'($urandom);
         @(negedge clk);
      end
      check("ready_timeout", 32'(ready_w[0]), 32'd1);
   endtask

   task automatic run_frame(input vec_t v);
      int lowcnt;
      digits = v.digits;
      valid  = 1'b1;
      push_frame(v.s_plain, v.s_hex, v.s_blz);
      @(negedge clk);
      valid = 1'b0;
      check("frame_busy", 32'(busy_w[0]), 32'd1);
      wait_ready(v.scramble, lowcnt);
      check($sformatf("frame_ready_low_%05h", v.digits), 32'(lowcnt), 32'd105);
      check("frame_busy_idle", 32'(busy_w[0]), 32'd0);
      check_queues_empty("frame");
   endtask

   initial begin
      int lowcnt;
      lbl = "NHOM 14: ";
      vecs[0] = '{20'h01234, "01234", "01234", " 1234", 1'b0};
      vecs[1] = '{20'hAF09C, "??09?", "AF09C", "??09?", 1'b1};
      vecs[2] = '{20'h00070, "00070", "00070", "   70", 1'b1};
      vecs[3] = '{20'h00000, "00000", "00000", "    0", 1'b1};
      vecs[4] = '{20'h90000, "90000", "90000", "90000", 1'b1};
      vecs[5] = '{20'h0000B, "0000?", "0000B", "    ?", 1'b1};
      vecs[6] = '{20'h00E05, "00?05", "00E05", "  ?05", 1'b1};
      vecs[7] = '{20'h10001, "10001", "10001", "10001", 1'b1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      run_init();

      for (int r = 0; r < 8; r++) run_frame(vecs[r]);

      // valid raised mid-frame is held off until IDLE, then captured at once
      digits = 20'h01234;
      valid  = 1'b1;
      push_frame("01234", "01234", " 1234");
      @(negedge clk);
      valid = 1'b0;
      repeat (50) @(negedge clk);
      digits = 20'h56789;
      valid  = 1'b1;
      push_frame("56789", "56789", "56789");
      @(negedge clk);
      check("busy_ready_low", 32'(ready_w[0]), 32'd0);
      wait_ready(1'b0, lowcnt);
      check("busy_ready_low_len", 32'(lowcnt), 32'd54);
      @(negedge clk);
      check("busy_capture_on_idle", 32'(ready_w[0]), 32'd0);
      valid = 1'b0;
      wait_ready(1'b1, lowcnt);
      check("busy_frame2_len", 32'(lowcnt), 32'd105);
      check_queues_empty("busy");

      // reset while byte 6 (label '1') has lcd_e high
      digits = 20'h01234;
      valid  = 1'b1;
      push_frame("01234", "01234", " 1234");
      @(negedge clk);
      valid = 1'b0;
      repeat (43) @(negedge clk);
      check("pre_reset_e_high", 32'(e_w[0]), 32'd1);
      check("pre_reset_data", 32'(data_w[0]), 32'h31);
      rst = 1'b1;
      @(negedge clk);
      check("reset_e_drop", 32'(e_w), 32'd0);
      repeat (2) @(negedge clk);
      run_init();
      run_frame(vecs[0]);

      repeat (5) @(negedge clk);
      check_queues_empty("end");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
      $fatal(1, "watchdog");
   end

endmodule
